// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC generator with redirect priority, stall-deferred redirects and flush pulse.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        is_jump,
    input  logic [31:0] jump_target,
    input  logic        is_branch,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        is_jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [1:0]  pc_select,
    output logic        fetch_valid,
    output logic        flush,
    output logic [15:0] redirect_count
);
    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;
    state_t      state;
    logic [1:0]  pend_sel;
    logic [31:0] pend_target;
    logic        taken;
    logic        redirect;
    logic        advance;
    logic [1:0]  run_sel;
    logic [31:0] run_target;
    logic [15:0] count_inc;
    always_comb begin
        taken      = is_branch && branch_taken;
        redirect   = is_jr || is_jump || taken;
        advance    = imem_ready && !stall;
        run_sel    = is_jr ? 2'd3 : is_jump ? 2'd0 : taken ? 2'd2 : 2'd1;
        run_target = (is_jr ? jr_target : is_jump ? jump_target : branch_target) & ~32'h3;
        pc_select  = state == RUN ? run_sel : state == PEND ? pend_sel : 2'd1;
        count_inc  = redirect_count == 16'hFFFF ? redirect_count : redirect_count + 16'd1;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= BOOT;
            pc             <= RESET_PC;
            flush          <= 1'b0;
            fetch_valid    <= 1'b0;
            redirect_count <= 16'd0;
            pend_sel       <= 2'd0;
            pend_target    <= 32'd0;
        end else begin
            flush <= 1'b0;
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                end
                RUN: begin
                    if (advance && redirect) begin
                        pc             <= run_target;
                        flush          <= 1'b1;
                        redirect_count <= count_inc;
                    end else if (advance) begin
                        pc <= pc + 32'd4;
                    end else if (redirect) begin
                        // first redirect seen while held is parked until fetch can move
                        pend_sel    <= run_sel;
                        pend_target <= run_target;
                        state       <= PEND;
                    end
                end
                PEND: begin
                    if (advance) begin
                        pc             <= pend_target;
                        flush          <= 1'b1;
                        redirect_count <= count_inc;
                        state          <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed spec scenarios plus randomized traffic against a behavioural PC model.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, imem_ready = 1'b1;
    logic        is_jump = 1'b0, is_branch = 1'b0, branch_taken = 1'b0, is_jr = 1'b0;
    logic [31:0] jump_target = '0, branch_target = '0, jr_target = '0;
    logic [31:0] pc;
    logic [1:0]  pc_select;
    logic        fetch_valid, flush;
    logic [15:0] redirect_count;
    int errors = 0, checks = 0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
        .is_jump(is_jump), .jump_target(jump_target),
        .is_branch(is_branch), .branch_taken(branch_taken), .branch_target(branch_target),
        .is_jr(is_jr), .jr_target(jr_target),
        .pc(pc), .pc_select(pc_select), .fetch_valid(fetch_valid), .flush(flush),
        .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // behavioural model: booting flag, optional parked redirect, pc, counter, flush
    logic        m_boot = 1'b1, m_pend = 1'b0, m_flush = 1'b0;
    logic [1:0]  m_psel = 2'd0;
    logic [31:0] m_pc = 32'd0, m_ptgt = 32'd0;
    logic [15:0] m_cnt = 16'd0;
    logic        r_any, adv;
    logic [1:0]  r_sel;
    logic [31:0] r_tgt;

    always_comb begin
        r_any = 1'b1;
        r_sel = 2'd1;
        r_tgt = 32'd0;
        if (is_jr) begin r_sel = 2'd3; r_tgt = jr_target; end
        else if (is_jump) begin r_sel = 2'd0; r_tgt = jump_target; end
        else if (is_branch && branch_taken) begin r_sel = 2'd2; r_tgt = branch_target; end
        else r_any = 1'b0;
        r_tgt = {r_tgt[31:2], 2'b00};
        adv = imem_ready && !stall;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_boot = 1'b1; m_pend = 1'b0; m_flush = 1'b0;
            m_pc = 32'd0; m_cnt = 16'd0; m_psel = 2'd0; m_ptgt = 32'd0;
        end else begin
            m_flush = 1'b0;
            if (m_boot) m_boot = 1'b0;
            else if (m_pend || r_any) begin
                if (adv) begin
                    m_pc = m_pend ? m_ptgt : r_tgt;
                    m_flush = 1'b1;
                    m_pend = 1'b0;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end else if (!m_pend) begin
                    m_pend = 1'b1; m_ptgt = r_tgt; m_psel = r_sel;
                end
            end else if (adv) m_pc = m_pc + 32'd4;
        end
    end

    always @(negedge clk) begin
        chk("pc", pc, m_pc);
        chk("pc_select", {30'd0, pc_select}, {30'd0, m_boot ? 2'd1 : m_pend ? m_psel : r_sel});
        chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, !m_boot});
        chk("flush", {31'd0, flush}, {31'd0, m_flush});
        chk("redirect_count", {16'd0, redirect_count}, {16'd0, m_cnt});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 1'b0; imem_ready = 1'b1;
        is_jump = 1'b0; is_branch = 1'b0; branch_taken = 1'b0; is_jr = 1'b0;
    endtask

    task automatic jump_to(input logic [31:0] t);
        is_jump = 1'b1; jump_target = t;
        step();
        idle();
    endtask

    initial begin
        idle();
        step(); step();
        reset = 1'b0;
        #1;
        chk("boot_pc", pc, 32'h0);
        chk("boot_fv", {31'd0, fetch_valid}, 32'd0);
        chk("boot_sel", {30'd0, pc_select}, 32'd1);
        step(); chk("run_pc0", pc, 32'h0); chk("run_fv", {31'd0, fetch_valid}, 32'd1);
        step(); chk("run_pc4", pc, 32'h4);
        step(); chk("run_pc8", pc, 32'h8);
        step(); chk("run_pcC", pc, 32'hC); chk("run_flush", {31'd0, flush}, 32'd0);

        jump_to(32'h100);
        chk("jmp_pc", pc, 32'h100);
        is_jr = 1'b1; jr_target = 32'h2003; is_jump = 1'b1; jump_target = 32'h400;
        #1; chk("prio_sel", {30'd0, pc_select}, 32'd3);
        step(); idle();
        chk("jr_pc", pc, 32'h2000); chk("jr_flush", {31'd0, flush}, 32'd1);
        chk("jr_cnt", {16'd0, redirect_count}, 32'd2);
        step(); chk("jr_flush_off", {31'd0, flush}, 32'd0); chk("jr_pc4", pc, 32'h2004);

        jump_to(32'h40);
        stall = 1'b1; is_branch = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
        step(); chk("st_pc0", pc, 32'h40); chk("st_flush0", {31'd0, flush}, 32'd0);
        is_branch = 1'b0; is_jump = 1'b1; jump_target = 32'h900;
        #1; chk("pend_sel", {30'd0, pc_select}, 32'd2);
        step(); chk("st_pc1", pc, 32'h40); chk("st_flush1", {31'd0, flush}, 32'd0);
        idle();
        step(); chk("st_pc2", pc, 32'h80); chk("st_flush2", {31'd0, flush}, 32'd1);
        step(); chk("st_pc3", pc, 32'h84); chk("st_flush3", {31'd0, flush}, 32'd0);

        jump_to(32'hFFFF_FFFC);
        step(); chk("wrap_pc", pc, 32'h0); chk("wrap_flush", {31'd0, flush}, 32'd0);

        stall = 1'b1; is_jump = 1'b1; jump_target = 32'h500;
        step(); idle(); stall = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_pc", pc, 32'h0); chk("rst_cnt", {16'd0, redirect_count}, 32'd0);
        chk("rst_fv", {31'd0, fetch_valid}, 32'd0); chk("rst_flush", {31'd0, flush}, 32'd0);
        step();
        reset = 1'b0; idle();
        step(); chk("rel_pc0", pc, 32'h0); chk("rel_flush0", {31'd0, flush}, 32'd0);
        step(); chk("rel_pc4", pc, 32'h4); chk("rel_flush1", {31'd0, flush}, 32'd0);
        step(); chk("rel_pc8", pc, 32'h8);

        for (int i = 0; i < 3000; i++) begin
            stall        = ($urandom_range(3) == 0);
            imem_ready   = ($urandom_range(3) != 0);
            is_jr        = ($urandom_range(9) == 0);
            is_jump      = ($urandom_range(7) == 0);
            is_branch    = ($urandom_range(4) == 0);
            branch_taken = $urandom_range(1) == 1;
            jr_target     = $urandom;
            jump_target   = $urandom;
            branch_target = $urandom;
            reset = ($urandom_range(299) == 0);
            step();
        end
        reset = 1'b0; idle();
        step();

        reset = 1'b1; step(); reset = 1'b0; step();
        is_branch = 1'b1; branch_taken = 1'b1; branch_target = 32'h1234;
        for (int i = 0; i < 65535; i++) step();
        chk("sat_65535", {16'd0, redirect_count}, 32'hFFFF);
        step();
        chk("sat_65536", {16'd0, redirect_count}, 32'hFFFF);
        idle();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
